clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL use parameter P_REPEAT_DLY, default 50_000_000; cycles a held U/D must stay high, counted from the first pulse, before auto-repeat starts.
REQ-002 SHALL use parameter P_REPEAT_PER, default 10_000_000; cycles between auto-repeat pulses.
REQ-003 SHALL use parameter P_BLINK_HALF, default 25_000_000; cycles per half-period of the field blink.
REQ-004 SHALL use parameter P_TIMEOUT, default 1_000_000_000; idle cycles in a set state before automatic exit.
REQ-005 SHALL have iClk  input  1  system clock, rising edge.
REQ-006 SHALL have iRst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have iClock_Mode  input  1  level; 1 = clock display mode is selected.
REQ-008 SHALL have iBtn_C, iBtn_L, iBtn_R  input  1 each  debounced single-cycle press pulses.
REQ-009 SHALL have iBtn_U, iBtn_D  input  1 each  debounced button levels.
REQ-010 SHALL have oSet_Active  output  1  high in any set state.
REQ-011 SHALL have oField  output  2  00 none, 01 sec, 10 min, 11 hour.
REQ-012 SHALL have oInc, oDec  output  1 each  single-cycle increment/decrement commands for the selected field.
REQ-013 SHALL have oBlink_On  output  1  1 = selected field visible.

Function
REQ-014 SHALL implement states IDLE, SET_SEC, SET_MIN, SET_HOUR; all outputs registered; every event takes effect at the edge that samples it.
REQ-015 SHALL go IDLE -> SET_MIN on iBtn_C while iClock_Mode=1; C is ignored in IDLE while iClock_Mode=0.
REQ-016 SHALL go from any set state to IDLE on iBtn_C.
REQ-017 SHALL rotate iBtn_R HOUR->MIN->SEC->HOUR and iBtn_L SEC->MIN->HOUR->SEC.
REQ-018 SHALL give priority C > L > R when pulses coincide.
REQ-019 SHALL force IDLE at the next edge when iClock_Mode=0 in a set state, overriding all buttons.
REQ-020 SHALL drive oField per state (IDLE=00) and oSet_Active = (state != IDLE).
REQ-021 SHALL pulse oInc for one cycle after an iBtn_U rising edge in a set state, and oDec likewise for iBtn_D.
REQ-022 SHALL treat iBtn_U=iBtn_D=1 as no command and hold the repeat counter at 0.
REQ-023 SHALL emit no oInc/oDec in IDLE and SHALL keep the U/D edge-detect registers updated in IDLE.
REQ-024 SHALL clear the repeat counter on any C/L/R pulse, restarting the P_REPEAT_DLY delay without emitting a pulse.
REQ-025 SHALL hold oBlink_On=1 in IDLE, load it to 1 and restart the blink counter on set entry, field change, or oInc/oDec, and otherwise toggle it every P_BLINK_HALF cycles.
REQ-026 SHALL reset the timeout counter on any button pulse or U/D level high, and go to IDLE after P_TIMEOUT consecutive inactive cycles.
REQ-027 SHALL size all counters to hold their parameter value, saturate none, and wrap none (each is cleared on terminal count).

Reset
REQ-028 SHALL on iRst force state IDLE, oField=00, oSet_Active=0, oInc=oDec=0, oBlink_On=1, and clear all counters and edge registers, including when asserted mid-hold or mid-set.
REQ-029 SHALL produce no oInc/oDec in the first cycle after reset release, even with U/D held low.

Configuration
REQ-030 SHALL, with macro CLOCK_SET_AUTOREPEAT_EN defined, generate a further pulse P_REPEAT_DLY cycles after the first pulse while U/D stays held, then one every P_REPEAT_PER cycles.
REQ-031 SHALL, without CLOCK_SET_AUTOREPEAT_EN, emit exactly one pulse per rising edge and omit the repeat counter.

Verification (P_REPEAT_DLY=8, P_REPEAT_PER=4, P_BLINK_HALF=5, P_TIMEOUT=40)
REQ-032 SHALL cover: iClock_Mode=1 with C pulse -> oField=10 next cycle; R,R,R -> 01,11,10; L -> 11; C -> 00.
REQ-033 SHALL cover: in SET_MIN, U held 30 cycles with macro on -> oInc at cycles 1, 9, 13, 17, 21, 25, 29 (7 pulses), and with macro off -> exactly 1 pulse.
REQ-034 SHALL cover: U and D rising in the same cycle -> no pulses; release D while U held -> no pulse until the next U rising edge.
REQ-035 SHALL cover: in SET_HOUR with no input for 40 cycles -> IDLE, with oBlink_On toggling every 5 cycles before exit and 1 after.
REQ-036 SHALL cover: iClock_Mode dropping while U is held in SET_SEC -> IDLE next cycle and no oInc thereafter.
REQ-037 SHALL cover: iRst asserted mid auto-repeat -> all outputs at reset values asynchronously; after release, C enters SET_MIN.

Source files
------------

// File: rtl/clock_set_if.sv
// Button and display-control bundle between the front panel and clock_set_ctrl.
// The master drives the button inputs; the slave (controller) drives the set-mode outputs.
interface clock_set_if;
  logic       iClock_Mode;
  logic       iBtn_C;
  logic       iBtn_L;
  logic       iBtn_R;
  logic       iBtn_U;
  logic       iBtn_D;
  logic       oSet_Active;
  logic [1:0] oField;
  logic       oInc;
  logic       oDec;
  logic       oBlink_On;

  modport master (
    output iClock_Mode, iBtn_C, iBtn_L, iBtn_R, iBtn_U, iBtn_D,
    input  oSet_Active, oField, oInc, oDec, oBlink_On
  );

  modport slave (
    input  iClock_Mode, iBtn_C, iBtn_L, iBtn_R, iBtn_U, iBtn_D,
    output oSet_Active, oField, oInc, oDec, oBlink_On
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: field selection, inc/dec commands, field blink and idle timeout.
// Optional feature macro: CLOCK_SET_AUTOREPEAT_EN enables auto-repeat of a held U/D button.
module clock_set_ctrl #(
  parameter int P_REPEAT_DLY = 50_000_000,
  parameter int P_REPEAT_PER = 10_000_000,
  parameter int P_BLINK_HALF = 25_000_000,
  parameter int P_TIMEOUT    = 1_000_000_000
) (
  input logic        iClk,
  input logic        iRst,
  clock_set_if.slave bus
);
  localparam int BLINK_W = $clog2(P_BLINK_HALF + 1);
  localparam int TMO_W   = $clog2(P_TIMEOUT + 1);

  if (P_REPEAT_DLY < 1 || P_REPEAT_PER < 1 || P_BLINK_HALF < 1 || P_TIMEOUT < 1) begin : g_param_check
    $error("clock_set_ctrl: all timing parameters must be at least 1");
  end

  // State codes double as the oField encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SET_SEC  = 2'b01,
    SET_MIN  = 2'b10,
    SET_HOUR = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic                 set_active_q, set_active_d;
  logic                 inc_q, inc_d, dec_q, dec_d;
  logic                 blink_q, blink_d;
  logic [BLINK_W-1:0]   bcnt_q, bcnt_d;
  logic [TMO_W-1:0]     tcnt_q, tcnt_d;
  logic                 u_prev_q, u_prev_d, d_prev_q, d_prev_d;
  logic                 any_btn, activity, stay_set, cmd_inc, cmd_dec;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (P_REPEAT_DLY > P_REPEAT_PER) ? P_REPEAT_DLY : P_REPEAT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             armed_q, armed_d, phase_q, phase_d;
`endif

  function automatic state_t rot_left(input state_t s);
    case (s)
      SET_SEC: rot_left = SET_MIN;
      SET_MIN: rot_left = SET_HOUR;
      default: rot_left = SET_SEC;
    endcase
  endfunction

  function automatic state_t rot_right(input state_t s);
    case (s)
      SET_HOUR: rot_right = SET_MIN;
      SET_MIN:  rot_right = SET_SEC;
      default:  rot_right = SET_HOUR;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    tcnt_d   = '0;
    u_prev_d = bus.iBtn_U;
    d_prev_d = bus.iBtn_D;
    any_btn  = bus.iBtn_C | bus.iBtn_L | bus.iBtn_R;
    activity = any_btn | bus.iBtn_U | bus.iBtn_D;

    // Mode loss and C override everything; timeout only runs on fully idle cycles.
    if (state_q == IDLE) begin
      if (bus.iBtn_C && bus.iClock_Mode) state_d = SET_MIN;
    end else if (!bus.iClock_Mode || bus.iBtn_C) begin
      state_d = IDLE;
    end else if (bus.iBtn_L) begin
      state_d = rot_left(state_q);
    end else if (bus.iBtn_R) begin
      state_d = rot_right(state_q);
    end else if (!activity) begin
      if (tcnt_q == TMO_W'(P_TIMEOUT - 1)) state_d = IDLE;
      else                                  tcnt_d  = tcnt_q + TMO_W'(1);
    end

    stay_set = (state_q != IDLE) && (state_d != IDLE);
    cmd_inc  = stay_set && bus.iBtn_U && !u_prev_q && !bus.iBtn_D;
    cmd_dec  = stay_set && bus.iBtn_D && !d_prev_q && !bus.iBtn_U;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    rpt_d   = '0;
    armed_d = 1'b0;
    phase_d = 1'b0;
    if (stay_set && (bus.iBtn_U ^ bus.iBtn_D)) begin
      if (cmd_inc || cmd_dec) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        armed_d = 1'b1;
        // A C/L/R pulse leaves the counter cleared, restarting the initial delay.
        if (!any_btn) begin
          if ((!phase_q && rpt_q == RPT_W'(P_REPEAT_DLY - 1)) ||
              ( phase_q && rpt_q == RPT_W'(P_REPEAT_PER - 1))) begin
            cmd_inc = bus.iBtn_U;
            cmd_dec = bus.iBtn_D;
            phase_d = 1'b1;
          end else begin
            rpt_d   = rpt_q + RPT_W'(1);
            phase_d = phase_q;
          end
        end
      end
    end
`endif

    inc_d        = cmd_inc;
    dec_d        = cmd_dec;
    set_active_d = (state_d != IDLE);

    if (state_d == IDLE || state_d != state_q || cmd_inc || cmd_dec) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BLINK_W'(P_BLINK_HALF - 1)) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= IDLE;
      set_active_q <= 1'b0;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      blink_q      <= 1'b1;
      bcnt_q       <= '0;
      tcnt_q       <= '0;
      u_prev_q     <= 1'b0;
      d_prev_q     <= 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      rpt_q        <= '0;
      armed_q      <= 1'b0;
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      set_active_q <= set_active_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      blink_q      <= blink_d;
      bcnt_q       <= bcnt_d;
      tcnt_q       <= tcnt_d;
      u_prev_q     <= u_prev_d;
      d_prev_q     <= d_prev_d;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      rpt_q        <= rpt_d;
      armed_q      <= armed_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign bus.oField      = state_q;
  assign bus.oSet_Active = set_active_q;
  assign bus.oInc        = inc_q;
  assign bus.oDec        = dec_q;
  assign bus.oBlink_On   = blink_q;
endmodule
